// File: rtl/seq_shift_unit.sv
// seq_shift_unit: one-bit-per-clock LSL/LSR/ASR/ROR shifter; start/command/in/shiftVal/c_in in, busy/done/out/carry_out/cmd_err out
module seq_shift_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       command,
  input  logic [WIDTH-1:0] in,
  input  logic [31:0]      shiftVal,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             cmd_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] count, n;
  logic [1:0] cmd;
  logic [WIDTH-1:0] sh_out;
  logic sh_c;
  always_comb begin
    n = command == 4'd3 ? CNT_W'(shiftVal[4:0]) :
        command > 4'd3 ? '0 :
        |shiftVal[31:5] ? CNT_W'(32) : CNT_W'(shiftVal[4:0]);
    sh_c = cmd == 2'd0 ? out[WIDTH-1] : out[0];
    sh_out = cmd == 2'd0 ? {out[WIDTH-2:0], 1'b0} :
             {cmd == 2'd1 ? 1'b0 : cmd == 2'd2 ? out[WIDTH-1] : out[0], out[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      out <= '0;
      carry_out <= 1'b0;
      cmd_err <= 1'b0;
      count <= '0;
      cmd <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            out <= in;
            cmd <= command[1:0];
            count <= n;
            if (n == '0) begin
              state <= DONE;
              done <= 1'b1;
              carry_out <= c_in;
              cmd_err <= command > 4'd3;
            end else begin
              state <= SHIFT;
              busy <= 1'b1;
              cmd_err <= 1'b0;
            end
          end
        end
        SHIFT: begin
          out <= sh_out;
          carry_out <= sh_c;
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed scoreboard bench for seq_shift_unit
module tb_seq_shift_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic c_in = 1'b0;
  logic [3:0] command = '0;
  logic [31:0] in = '0;
  logic [31:0] shiftVal = '0;
  logic busy, done, carry_out, cmd_err;
  logic [31:0] out;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] o;
    logic c;
    logic err;
    int n;
  } exp_t;
  exp_t q[$];
  seq_shift_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .command(command), .in(in),
    .shiftVal(shiftVal), .c_in(c_in), .busy(busy), .done(done), .out(out),
    .carry_out(carry_out), .cmd_err(cmd_err)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] d, input logic [31:0] s, input logic ci);
    exp_t r;
    logic [63:0] w;
    logic signed [63:0] sw;
    int n;
    n = c == 4'd3 ? int'(s[4:0]) : c > 4'd3 ? 0 : (s >= 32 ? 32 : int'(s));
    r.n = n;
    r.err = c > 4'd3;
    r.o = d;
    r.c = ci;
    if (n > 0) begin
      if (c == 4'd0) begin
        w = {32'b0, d} << n;
        r.o = w[31:0];
        r.c = d[32-n];
      end else if (c == 4'd1) begin
        w = {32'b0, d} >> n;
        r.o = w[31:0];
        r.c = d[n-1];
      end else if (c == 4'd2) begin
        sw = {{32{d[31]}}, d};
        sw = sw >>> n;
        r.o = sw[31:0];
        r.c = d[n-1];
      end else begin
        w = {d, d} >> n;
        r.o = w[31:0];
        r.c = d[n-1];
      end
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [3:0] c, input logic [31:0] d, input logic [31:0] s, input logic ci, input bit disturb);
    exp_t e;
    int k, bc;
    command = c;
    in = d;
    shiftVal = s;
    c_in = ci;
    start = 1'b1;
    q.push_back(model(c, d, s, ci));
    @(posedge clk);
    #1;
    start = 1'b0;
    if (disturb) begin
      start = 1'b1;
      in = ~d;
      command = 4'd1;
      shiftVal = 32'd2;
      c_in = ~ci;
    end
    bc = busy ? 1 : 0;
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (!done && busy) bc++;
    end
    start = 1'b0;
    e = q.pop_front();
    chk("done_seen", 64'(done), 64'(1));
    chk("latency", 64'(k), 64'(e.n));
    chk("busy_cycles", 64'(bc), 64'(e.n));
    chk("busy_at_done", 64'(busy), 64'(0));
    chk("out", 64'(out), 64'(e.o));
    chk("carry_out", 64'(carry_out), 64'(e.c));
    chk("cmd_err", 64'(cmd_err), 64'(e.err));
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(done), 64'(0));
    @(posedge clk);
    #1;
    chk("done_idle", 64'(done), 64'(0));
    chk("out_hold", 64'(out), 64'(e.o));
    chk("carry_hold", 64'(carry_out), 64'(e.c));
    chk("err_hold", 64'(cmd_err), 64'(e.err));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_out", 64'(out), 64'(0));
    chk("rst_carry", 64'(carry_out), 64'(0));
    chk("rst_err", 64'(cmd_err), 64'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    run(4'd0, 32'h8000000A, 32'd3, 1'b0, 1'b0);
    run(4'd1, 32'h8000000A, 32'd3, 1'b0, 1'b0);
    run(4'd2, 32'h8000000A, 32'd3, 1'b0, 1'b0);
    run(4'd3, 32'h8000000A, 32'd3, 1'b0, 1'b0);
    run(4'd0, 32'h00000001, 32'd40, 1'b0, 1'b0);
    run(4'd2, 32'h80000000, 32'd100, 1'b0, 1'b0);
    run(4'd1, 32'h80000001, 32'd32, 1'b0, 1'b0);
    run(4'd2, 32'h7FFF0000, 32'hFFFFFFFF, 1'b1, 1'b0);
    run(4'd1, 32'h12345678, 32'd0, 1'b1, 1'b0);
    run(4'd7, 32'hCAFEBABE, 32'd5, 1'b0, 1'b0);
    run(4'd15, 32'h0000FFFF, 32'd0, 1'b1, 1'b0);
    run(4'd1, 32'h0F0F0F0F, 32'd0, 1'b0, 1'b0);
    run(4'd3, 32'hDEADBEEF, 32'd64, 1'b1, 1'b0);
    run(4'd3, 32'hDEADBEEF, 32'd35, 1'b0, 1'b0);
    run(4'd3, 32'h00000001, 32'd31, 1'b0, 1'b0);
    run(4'd0, 32'hC0000003, 32'd1, 1'b0, 1'b0);
    run(4'd0, 32'h13572468, 32'd5, 1'b0, 1'b1);
    run(4'd2, 32'h80001234, 32'd4, 1'b1, 1'b1);
    command = 4'd0;
    in = 32'hFFFFFFFF;
    shiftVal = 32'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_out", 64'(out), 64'(0));
    chk("mid_rst_carry", 64'(carry_out), 64'(0));
    chk("mid_rst_err", 64'(cmd_err), 64'(0));
    repeat (12) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle", 64'({busy, done}), 64'(0));
    end
    run(4'd1, 32'hA5A5A5A5, 32'd7, 1'b0, 1'b0);
    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
